// File: rtl/ddsm_mash_ncl.sv
// MASH 1-1-1 noise-cancellation stage: turns the three accumulator carry bits into one signed output word.
// Optional NCL_OFFSET_EN: emit y + 3 as offset binary instead of two's complement.
module ddsm_mash_ncl #(
  parameter int P_OUT_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_vld,
  input  logic                   i_c1,
  input  logic                   i_c2,
  input  logic                   i_c3,
  output logic [P_OUT_WIDTH-1:0] o_y,
  output logic                   o_vld,
  output logic                   o_primed,
  output logic [1:0]             o_dbg_state
);

  // State encoding doubles as the 2-bit saturating prime counter.
  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ONE    = 2'd1,
    S_PRIMED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_c1_d1, r_c1_d2;
  logic                   r_c2_d1, r_c2_d2;
  logic                   r_c3_d1, r_c3_d2;
  logic [P_OUT_WIDTH-1:0] r_y;
  logic                   r_vld;
  logic                   w_acc;
  logic [P_OUT_WIDTH-1:0] w_y;
  logic [P_OUT_WIDTH-1:0] w_y_out;

  // Handshake: i_vld is a one-cycle strobe with no back-pressure; o_vld pulses
  // for exactly one cycle per output and the consumer must accept every pulse.
  assign w_acc = i_vld & ~i_clr;

  // Modular arithmetic at P_OUT_WIDTH yields the correct two's-complement sum.
  assign w_y = P_OUT_WIDTH'(r_c1_d2)
             + P_OUT_WIDTH'(r_c2_d1) - P_OUT_WIDTH'(r_c2_d2)
             + P_OUT_WIDTH'(i_c3) - (P_OUT_WIDTH'(r_c3_d1) << 1) + P_OUT_WIDTH'(r_c3_d2);

`ifdef NCL_OFFSET_EN
  assign w_y_out = w_y + P_OUT_WIDTH'(3);
`else
  assign w_y_out = w_y;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (i_clr) begin
      w_state_nxt = S_EMPTY;
    end else if (i_vld) begin
      case (r_state)
        S_EMPTY: w_state_nxt = S_ONE;
        S_ONE:   w_state_nxt = S_PRIMED;
        default: w_state_nxt = S_PRIMED;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c1_d1 <= 1'b0;
      r_c1_d2 <= 1'b0;
      r_c2_d1 <= 1'b0;
      r_c2_d2 <= 1'b0;
      r_c3_d1 <= 1'b0;
      r_c3_d2 <= 1'b0;
      r_y     <= '0;
      r_vld   <= 1'b0;
    end else if (i_clr) begin
      r_c1_d1 <= 1'b0;
      r_c1_d2 <= 1'b0;
      r_c2_d1 <= 1'b0;
      r_c2_d2 <= 1'b0;
      r_c3_d1 <= 1'b0;
      r_c3_d2 <= 1'b0;
      r_y     <= '0;
      r_vld   <= 1'b0;
    end else if (w_acc) begin
      r_c1_d1 <= i_c1;
      r_c1_d2 <= r_c1_d1;
      r_c2_d1 <= i_c2;
      r_c2_d2 <= r_c2_d1;
      r_c3_d1 <= i_c3;
      r_c3_d2 <= r_c3_d1;
      r_vld   <= (r_state == S_PRIMED);
      if (r_state == S_PRIMED) begin
        r_y <= w_y_out;
      end
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign o_y         = r_y;
  assign o_vld       = r_vld;
  assign o_primed    = (r_state == S_PRIMED);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ddsm_mash_ncl.sv
// Directed and randomised bench for ddsm_mash_ncl with a reference model feeding an expected queue.
module tb_ddsm_mash_ncl;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         vld;
  logic         c1, c2, c3;
  logic [W-1:0] y;
  logic         y_vld;
  logic         primed;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int m_c1d1, m_c1d2, m_c2d1, m_c2d2, m_c3d1, m_c3d2, m_cnt;
  logic [W-1:0] last_y;

  ddsm_mash_ncl #(.P_OUT_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_vld(vld),
    .i_c1(c1), .i_c2(c2), .i_c3(c3),
    .o_y(y), .o_vld(y_vld), .o_primed(primed), .o_dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] enc(input int val);
`ifdef NCL_OFFSET_EN
    return W'(val + 3);
`else
    return W'(val);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_c1d1 = 0; m_c1d2 = 0; m_c2d1 = 0; m_c2d2 = 0; m_c3d1 = 0; m_c3d2 = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // Scoreboard compare after the edge: o_vld must match queue pushes, o_primed the model count.
  task automatic score(input bit pushed);
    logic [W-1:0] e;
    if (pushed) begin
      check("o_vld_hi", 32'(y_vld), 32'd1);
      if (exp_q.size() == 0) begin
        check("queue_nonempty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("o_y", 32'(y), 32'(e));
      end
      last_y = y;
    end else begin
      check("o_vld_lo", 32'(y_vld), 32'd0);
    end
    check("o_primed", 32'(primed), (m_cnt == 2) ? 32'd1 : 32'd0);
    check("dbg_state", 32'(dbg_state), 32'(m_cnt));
  endtask

  // driver tasks
  task automatic send(input bit a, input bit b, input bit c);
    bit pushed;
    int yv;
    @(negedge clk);
    vld = 1'b1; clr = 1'b0; c1 = a; c2 = b; c3 = c;
    pushed = (m_cnt == 2);
    if (pushed) begin
      yv = m_c1d2 + (m_c2d1 - m_c2d2) + (int'(c) - 2 * m_c3d1 + m_c3d2);
      exp_q.push_back(enc(yv));
    end
    m_c1d2 = m_c1d1; m_c1d1 = int'(a);
    m_c2d2 = m_c2d1; m_c2d1 = int'(b);
    m_c3d2 = m_c3d1; m_c3d1 = int'(c);
    if (m_cnt < 2) m_cnt++;
    @(posedge clk); #1;
    vld = 1'b0;
    score(pushed);
  endtask

  task automatic idle();
    @(negedge clk);
    vld = 1'b0; clr = 1'b0;
    c1 = 1'($urandom_range(0, 1)); c2 = 1'($urandom_range(0, 1)); c3 = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    score(1'b0);
  endtask

  task automatic do_clear(input bit with_vld);
    @(negedge clk);
    clr = 1'b1; vld = with_vld; c1 = 1'b1; c2 = 1'b1; c3 = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; vld = 1'b0;
    model_reset();
    check("clr_o_vld", 32'(y_vld), 32'd0);
    check("clr_o_y", 32'(y), 32'd0);
    check("clr_o_primed", 32'(primed), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; vld = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
    last_y = '0;
    model_reset();
    #12;
    check("rst_o_y", 32'(y), 32'd0);
    check("rst_o_vld", 32'(y_vld), 32'd0);
    check("rst_o_primed", 32'(primed), 32'd0);
    @(negedge clk); rst = 1'b0;

    // All-zero stream: primed after 2, outputs on 3..10 equal to encoded 0.
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 1'b0);

    // c3 = 1,0,1 -> +2
    do_clear(1'b0);
    send(0, 0, 1); send(0, 0, 0); send(0, 0, 1);
    check("c3_101", 32'(last_y), 32'(enc(2)));

    // c3 = 0,1,0 -> -2
    do_clear(1'b0);
    send(0, 0, 0); send(0, 0, 1); send(0, 0, 0);
    check("c3_010", 32'(last_y), 32'(enc(-2)));

    // Maximum +4
    do_clear(1'b0);
    send(1, 0, 1); send(0, 1, 0); send(0, 0, 1);
    check("max_p4", 32'(last_y), 32'(enc(4)));

    // Minimum -3
    do_clear(1'b0);
    send(0, 1, 0); send(0, 0, 1); send(0, 0, 0);
    check("min_m3", 32'(last_y), 32'(enc(-3)));

    // Gapped valid: idle cycles must not shift history.
    do_clear(1'b0);
    send(0, 0, 1); idle(); idle(); send(0, 0, 0); idle(); send(0, 0, 1);
    check("gapped", 32'(last_y), 32'(enc(2)));

    // Clear together with valid after priming; next two samples produce nothing.
    send(0, 1, 0);
    do_clear(1'b1);
    send(1, 1, 1); send(0, 1, 1); send(1, 0, 1);

    // Asynchronous reset between edges after a non-zero output.
    do_clear(1'b0);
    send(1, 0, 1); send(0, 1, 0); send(0, 0, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_o_y", 32'(y), 32'd0);
    check("async_o_vld", 32'(y_vld), 32'd0);
    check("async_o_primed", 32'(primed), 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    send(0, 0, 1); send(1, 1, 0); send(0, 0, 1);

    // Randomised stream with gaps.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
